// File: rtl/uart_rx_mv.sv
// 8N1 serial receiver: 2-flop synchronizer, 3-sample majority vote around mid-bit,
// false-start rejection, sticky framing/overrun flags and a ready/ready_clr handshake.
module uart_rx_mv #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_clk_en,
  input  logic                 ready_clr,
  output logic                 ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] MID      = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] MID_M1   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] MID_P1   = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_n;
  logic                 rx_meta, rxs;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 smp_a, smp_a_n, smp_b, smp_b_n;
  logic                 ready_n, frame_err_n, overrun_n;
  logic [DATA_BITS-1:0] data_out_n;
  logic                 vote;

  // Third vote input is the live sample on the MID+1 tick.
  assign vote = (smp_a & smp_b) | (smp_a & rxs) | (smp_b & rxs);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    shift_n     = shift;
    smp_a_n     = smp_a;
    smp_b_n     = smp_b;
    data_out_n  = data_out;
    ready_n     = ready & ~ready_clr;
    frame_err_n = frame_err & ~ready_clr;
    overrun_n   = overrun & ~ready_clr;

    if (rx_clk_en) begin
      if (state != IDLE) begin
        cnt_n = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
        if (cnt == MID_M1) smp_a_n = rxs;
        if (cnt == MID)    smp_b_n = rxs;
      end
      case (state)
        IDLE: begin
          // The detecting tick is tick 0 of the start bit.
          if (!rxs) begin
            state_n = START;
            cnt_n   = CW'(1);
          end
        end
        START: begin
          if (cnt == MID_P1 && vote) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (cnt == CNT_LAST) begin
            state_n = DATA;
            idx_n   = '0;
          end
        end
        DATA: begin
          if (cnt == MID_P1) shift_n = {vote, shift[DATA_BITS-1:1]};
          if (cnt == CNT_LAST) begin
            if (idx == IDX_LAST) state_n = STOP;
            else                 idx_n   = idx + IW'(1);
          end
        end
        STOP: begin
          // Leave on the vote tick so the next start edge is caught early.
          if (cnt == MID_P1) begin
            state_n = IDLE;
            cnt_n   = '0;
            if (vote) begin
              data_out_n = shift;
              ready_n    = 1'b1;
              if (ready && !ready_clr) overrun_n = 1'b1;
            end else begin
              frame_err_n = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      smp_a     <= 1'b1;
      smp_b     <= 1'b1;
      ready     <= 1'b0;
      data_out  <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rxs       <= rx_meta;
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift     <= shift_n;
      smp_a     <= smp_a_n;
      smp_b     <= smp_b_n;
      ready     <= ready_n;
      data_out  <= data_out_n;
      frame_err <= frame_err_n;
      overrun   <= overrun_n;
    end
  end

endmodule

// File: tb/tb_uart_rx_mv.sv
// Bench for uart_rx_mv: random and directed frames checked against a
// frame-level model of the handshake and sticky flags.
module tb_uart_rx_mv;

  logic       clk = 1'b0;
  logic       rst, rx, rx_clk_en, ready_clr;
  logic       ready, frame_err, overrun;
  logic [7:0] data_out;

  int n_cmp = 0;
  int n_bad = 0;
  int dv    = 1;
  int tc    = 0;

  bit       m_ready, m_ferr, m_ovr;
  bit [7:0] m_data;

  uart_rx_mv #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_clk_en(rx_clk_en), .ready_clr(ready_clr),
    .ready(ready), .data_out(data_out), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Sample tick: one clk out of every dv.
  initial begin
    rx_clk_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tc++;
      rx_clk_en = (tc % dv == 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_ready = 0; m_ferr = 0; m_ovr = 0; m_data = 8'h00;
  endtask

  task automatic m_clear();
    m_ready = 0; m_ferr = 0; m_ovr = 0;
  endtask

  // One complete frame reaching the receiver; clr_same = consumer ack on the commit clk.
  task automatic m_frame(input bit [7:0] b, input bit stop, input bit clr_same);
    if (clr_same) begin
      m_ovr  = 0;
      m_ferr = 0;
    end
    if (stop) begin
      if (m_ready && !clr_same) m_ovr = 1;
      m_ready = 1;
      m_data  = b;
    end else begin
      m_ferr = 1;
      if (clr_same) m_ready = 0;
    end
  endtask

  task automatic check_all(input string tag);
    @(negedge clk);
    chk({tag, ".ready"},     32'(ready),     32'(m_ready));
    chk({tag, ".data"},      32'(data_out),  32'(m_data));
    chk({tag, ".frame_err"}, 32'(frame_err), 32'(m_ferr));
    chk({tag, ".overrun"},   32'(overrun),   32'(m_ovr));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rx = 1'b1;
      ready_clr = 1'b0;
    end
  endtask

  // Drives start, 8 data bits LSB first, stop; nclk < full length truncates the frame.
  // inv flips rx for one clk at a random one of the three mid positions of each bit
  // (only meaningful with a tick every clk, where that clk maps onto one sample).
  task automatic send_frame(input bit [7:0] b, input bit stop, input bit inv,
                            input int clr_at, input int nclk);
    bit bits [10];
    int ip   [10];
    int bt, len, bi, k;
    bt = 16 * dv;
    len = (nclk < 10 * bt) ? nclk : 10 * bt;
    bits[0] = 1'b0;
    for (int j = 0; j < 8; j++) bits[j+1] = b[j];
    bits[9] = stop;
    for (int j = 0; j < 10; j++) ip[j] = $urandom_range(7, 9);
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      #1;
      bi = i / bt;
      k  = i % bt;
      rx = (inv && dv == 1 && k == ip[bi]) ? ~bits[bi] : bits[bi];
      ready_clr = (i == clr_at);
    end
    @(posedge clk);
    #1;
    rx = 1'b1;
    ready_clr = 1'b0;
  endtask

  task automatic clr_pulse(input string tag);
    @(posedge clk);
    #1;
    ready_clr = 1'b1;
    @(posedge clk);
    #1;
    ready_clr = 1'b0;
    m_clear();
    check_all(tag);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    rx  = 1'b1;
    ready_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
  endtask

  initial begin
    bit [7:0] b;
    bit       st;
    rst = 1'b1; rx = 1'b1; ready_clr = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
    check_all("reset");

    // Bad stop bit.
    dv = 1;
    send_frame(8'h3C, 1'b0, 0, -1, 10000); idle(40);
    m_frame(8'h3C, 1'b0, 0);
    check_all("ferr");
    clr_pulse("ferr_clr");

    send_frame(8'hA5, 1'b1, 0, -1, 10000); idle(40);
    m_frame(8'hA5, 1'b1, 0);
    check_all("a5");
    clr_pulse("a5_clr");

    // False start: 3 low ticks then high.
    repeat (3) begin @(posedge clk); #1; rx = 1'b0; end
    idle(40);
    check_all("glitch");
    send_frame(8'h3C, 1'b1, 0, -1, 10000); idle(40);
    m_frame(8'h3C, 1'b1, 0);
    check_all("after_glitch");
    clr_pulse("glitch_clr");

    // Overrun.
    send_frame(8'h11, 1'b1, 0, -1, 10000); idle(40);
    m_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0, -1, 10000); idle(40);
    m_frame(8'h22, 1'b1, 0);
    check_all("overrun");
    clr_pulse("overrun_clr");

    // Ack landing on the commit clk: stop vote tick is clk index 155 of the frame.
    send_frame(8'h44, 1'b1, 0, -1, 10000); idle(40);
    m_frame(8'h44, 1'b1, 0);
    send_frame(8'h7E, 1'b1, 0, 155, 10000); idle(40);
    m_frame(8'h7E, 1'b1, 1);
    check_all("clr_commit");
    clr_pulse("clr_commit_clr");

    // One mid sample corrupted in every bit.
    send_frame(8'h5A, 1'b1, 1, -1, 10000); idle(40);
    m_frame(8'h5A, 1'b1, 0);
    check_all("vote");
    clr_pulse("vote_clr");

    // Tick every 4th clk.
    dv = 4;
    send_frame(8'h5A, 1'b1, 0, -1, 10000); idle(160);
    m_frame(8'h5A, 1'b1, 0);
    check_all("div4");
    clr_pulse("div4_clr");

    // Break: repeated framing errors, never ready.
    dv = 1;
    @(posedge clk); #1; rx = 1'b0;
    repeat (400) @(posedge clk);
    m_frame(8'h00, 1'b0, 0);
    check_all("break");
    do_reset();
    check_all("break_rst");

    // Random frames, tick divisor, stop-bit errors and acks.
    for (int n = 0; n < 10; n++) begin
      dv = $urandom_range(1, 4);
      b  = 8'($urandom);
      st = ($urandom_range(0, 5) != 0);
      send_frame(b, st, (dv == 1), -1, 10000);
      idle(40 * dv);
      m_frame(b, st, 0);
      check_all($sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) == 1) clr_pulse($sformatf("rnd%0d_clr", n));
    end

    // Reset after data bit 3, then a clean frame.
    dv = 1;
    send_frame(8'hFF, 1'b1, 0, -1, 80);
    do_reset();
    idle(20);
    send_frame(8'hC3, 1'b1, 0, -1, 10000); idle(40);
    m_frame(8'hC3, 1'b1, 0);
    check_all("rst_mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
